// File: rtl/vram_pkg.sv
// Shared VRAM write-path types and constants: address map, region encoding and
// requester indices used by the write arbiter and its round-robin core.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 13;
    localparam int unsigned VRAM_DATA_W = 64;
    localparam int unsigned VRAM_BE_W   = VRAM_DATA_W / 8;
    localparam int unsigned NUM_REQ     = 3;

    localparam logic [1:0] REQ_H2F   = 2'd0;
    localparam logic [1:0] REQ_SYNC1 = 2'd1;
    localparam logic [1:0] REQ_SYNC2 = 2'd2;

    // Word-address bases; each region ends where the next one starts.
    localparam logic [VRAM_ADDR_W-1:0] TILE_BASE = 13'h0000;
    localparam logic [VRAM_ADDR_W-1:0] PAT_BASE  = 13'h0800;
    localparam logic [VRAM_ADDR_W-1:0] PAL_BASE  = 13'h1800;
    localparam logic [VRAM_ADDR_W-1:0] SPR_BASE  = 13'h1A00;
    localparam logic [VRAM_ADDR_W-1:0] RSVD_BASE = 13'h1A80;

    localparam int unsigned TILE_AW = 11;
    localparam int unsigned PAT_AW  = 12;
    localparam int unsigned PAL_AW  = 9;
    localparam int unsigned SPR_AW  = 7;

    typedef enum logic [2:0] {
        REG_TILE,
        REG_PAT,
        REG_PAL,
        REG_SPR,
        REG_RSVD
    } region_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant. The search starts one past the last accepted
// requester; the pointer only moves when the caller reports an accept.
module rr_arbiter3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       enable,
    input  logic       accept,
    output logic [2:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] ptr_q, ptr_d;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    always_comb begin
        logic [1:0] cand;
        logic       found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = next_idx(ptr_q);
        if (enable) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && req[cand]) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    found       = 1'b1;
                end
                cand = next_idx(cand);
            end
        end
    end

    always_comb begin
        ptr_d = accept ? grant_idx : ptr_q;
    end

    // Reset to 2 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 2'd2;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vram_wr_arbiter.sv
// Arbitrates three VRAM writers onto the region write ports with a registered
// one-cycle write pulse; reserved-address writes are accepted and counted.
module vram_wr_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][VRAM_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][VRAM_DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0][VRAM_BE_W-1:0]   req_byteena,
    input  logic                                wr_stall,
    output logic [TILE_AW-1:0]                  tile_wraddr,
    output logic                                tile_wren,
    output logic [VRAM_DATA_W-1:0]              tile_wrdata,
    output logic [VRAM_BE_W-1:0]                tile_byteena,
    output logic [PAT_AW-1:0]                   pat_wraddr,
    output logic                                pat_wren,
    output logic [VRAM_DATA_W-1:0]              pat_wrdata,
    output logic [VRAM_BE_W-1:0]                pat_byteena,
    output logic [PAL_AW-1:0]                   pal_wraddr,
    output logic                                pal_wren,
    output logic [VRAM_DATA_W-1:0]              pal_wrdata,
    output logic [VRAM_BE_W-1:0]                pal_byteena,
    output logic [SPR_AW-1:0]                   spr_wraddr,
    output logic                                spr_wren,
    output logic [VRAM_DATA_W-1:0]              spr_wrdata,
    output logic [VRAM_BE_W-1:0]                spr_byteena,
    output logic                                drop_err,
    output logic [DROP_CNT_W-1:0]               drop_cnt
);

    logic [NUM_REQ-1:0] grant;
    logic [1:0]         grant_idx;
    logic               arb_en;
    logic               handshake;

    assign arb_en    = rst_n & ~wr_stall;
    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    rr_arbiter3 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .enable    (arb_en),
        .accept    (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    logic [VRAM_ADDR_W-1:0] sel_addr;
    logic [VRAM_DATA_W-1:0] sel_data;
    logic [VRAM_BE_W-1:0]   sel_be;
    region_e                sel_region;

    always_comb begin
        case (grant_idx)
            REQ_SYNC1: begin
                sel_addr = req_addr[1];
                sel_data = req_data[1];
                sel_be   = req_byteena[1];
            end
            REQ_SYNC2: begin
                sel_addr = req_addr[2];
                sel_data = req_data[2];
                sel_be   = req_byteena[2];
            end
            default: begin
                sel_addr = req_addr[REQ_H2F];
                sel_data = req_data[REQ_H2F];
                sel_be   = req_byteena[REQ_H2F];
            end
        endcase
    end

    always_comb begin
        if (sel_addr < PAT_BASE) begin
            sel_region = REG_TILE;
        end else if (sel_addr < PAL_BASE) begin
            sel_region = REG_PAT;
        end else if (sel_addr < SPR_BASE) begin
            sel_region = REG_PAL;
        end else if (sel_addr < RSVD_BASE) begin
            sel_region = REG_SPR;
        end else begin
            sel_region = REG_RSVD;
        end
    end

    logic [TILE_AW-1:0]     tile_addr_q, tile_addr_d;
    logic [VRAM_DATA_W-1:0] tile_data_q, tile_data_d;
    logic [VRAM_BE_W-1:0]   tile_be_q, tile_be_d;
    logic                   tile_wren_q, tile_wren_d;
    logic [PAT_AW-1:0]      pat_addr_q, pat_addr_d;
    logic [VRAM_DATA_W-1:0] pat_data_q, pat_data_d;
    logic [VRAM_BE_W-1:0]   pat_be_q, pat_be_d;
    logic                   pat_wren_q, pat_wren_d;
    logic [PAL_AW-1:0]      pal_addr_q, pal_addr_d;
    logic [VRAM_DATA_W-1:0] pal_data_q, pal_data_d;
    logic [VRAM_BE_W-1:0]   pal_be_q, pal_be_d;
    logic                   pal_wren_q, pal_wren_d;
    logic [SPR_AW-1:0]      spr_addr_q, spr_addr_d;
    logic [VRAM_DATA_W-1:0] spr_data_q, spr_data_d;
    logic [VRAM_BE_W-1:0]   spr_be_q, spr_be_d;
    logic                   spr_wren_q, spr_wren_d;
    logic                   drop_err_q, drop_err_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    // Region bases other than pattern are aligned to their size, so the local
    // address is a plain slice; pattern wraps modulo 4K to remove its offset.
    always_comb begin
        tile_addr_d = tile_addr_q;
        tile_data_d = tile_data_q;
        tile_be_d   = tile_be_q;
        tile_wren_d = 1'b0;
        pat_addr_d  = pat_addr_q;
        pat_data_d  = pat_data_q;
        pat_be_d    = pat_be_q;
        pat_wren_d  = 1'b0;
        pal_addr_d  = pal_addr_q;
        pal_data_d  = pal_data_q;
        pal_be_d    = pal_be_q;
        pal_wren_d  = 1'b0;
        spr_addr_d  = spr_addr_q;
        spr_data_d  = spr_data_q;
        spr_be_d    = spr_be_q;
        spr_wren_d  = 1'b0;
        drop_err_d  = drop_err_q;
        drop_cnt_d  = drop_cnt_q;
        if (handshake) begin
            unique case (sel_region)
                REG_TILE: begin
                    tile_wren_d = 1'b1;
                    tile_addr_d = sel_addr[TILE_AW-1:0];
                    tile_data_d = sel_data;
                    tile_be_d   = sel_be;
                end
                REG_PAT: begin
                    pat_wren_d = 1'b1;
                    pat_addr_d = sel_addr[PAT_AW-1:0] - PAT_BASE[PAT_AW-1:0];
                    pat_data_d = sel_data;
                    pat_be_d   = sel_be;
                end
                REG_PAL: begin
                    pal_wren_d = 1'b1;
                    pal_addr_d = sel_addr[PAL_AW-1:0];
                    pal_data_d = sel_data;
                    pal_be_d   = sel_be;
                end
                REG_SPR: begin
                    spr_wren_d = 1'b1;
                    spr_addr_d = sel_addr[SPR_AW-1:0];
                    spr_data_d = sel_data;
                    spr_be_d   = sel_be;
                end
                REG_RSVD: begin
                    drop_err_d = 1'b1;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tile_addr_q <= '0;
            tile_data_q <= '0;
            tile_be_q   <= '0;
            tile_wren_q <= 1'b0;
            pat_addr_q  <= '0;
            pat_data_q  <= '0;
            pat_be_q    <= '0;
            pat_wren_q  <= 1'b0;
            pal_addr_q  <= '0;
            pal_data_q  <= '0;
            pal_be_q    <= '0;
            pal_wren_q  <= 1'b0;
            spr_addr_q  <= '0;
            spr_data_q  <= '0;
            spr_be_q    <= '0;
            spr_wren_q  <= 1'b0;
            drop_err_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            tile_addr_q <= tile_addr_d;
            tile_data_q <= tile_data_d;
            tile_be_q   <= tile_be_d;
            tile_wren_q <= tile_wren_d;
            pat_addr_q  <= pat_addr_d;
            pat_data_q  <= pat_data_d;
            pat_be_q    <= pat_be_d;
            pat_wren_q  <= pat_wren_d;
            pal_addr_q  <= pal_addr_d;
            pal_data_q  <= pal_data_d;
            pal_be_q    <= pal_be_d;
            pal_wren_q  <= pal_wren_d;
            spr_addr_q  <= spr_addr_d;
            spr_data_q  <= spr_data_d;
            spr_be_q    <= spr_be_d;
            spr_wren_q  <= spr_wren_d;
            drop_err_q  <= drop_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Gating with rst_n discards a registered write the moment reset asserts.
    assign tile_wren    = tile_wren_q & rst_n;
    assign tile_wraddr  = tile_addr_q;
    assign tile_wrdata  = tile_data_q;
    assign tile_byteena = tile_be_q;
    assign pat_wren     = pat_wren_q & rst_n;
    assign pat_wraddr   = pat_addr_q;
    assign pat_wrdata   = pat_data_q;
    assign pat_byteena  = pat_be_q;
    assign pal_wren     = pal_wren_q & rst_n;
    assign pal_wraddr   = pal_addr_q;
    assign pal_wrdata   = pal_data_q;
    assign pal_byteena  = pal_be_q;
    assign spr_wren     = spr_wren_q & rst_n;
    assign spr_wraddr   = spr_addr_q;
    assign spr_wrdata   = spr_data_q;
    assign spr_byteena  = spr_be_q;
    assign drop_err     = drop_err_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter: the driver queues each expected region
// write, a negedge monitor matches queued writes against the wren pulses.
module tb_vram_wr_arbiter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic [2:0][12:0]  req_addr;
    logic [2:0][63:0]  req_data;
    logic [2:0][7:0]   req_byteena;
    logic              wr_stall;
    logic [10:0]       tile_wraddr;
    logic              tile_wren;
    logic [63:0]       tile_wrdata;
    logic [7:0]        tile_byteena;
    logic [11:0]       pat_wraddr;
    logic              pat_wren;
    logic [63:0]       pat_wrdata;
    logic [7:0]        pat_byteena;
    logic [8:0]        pal_wraddr;
    logic              pal_wren;
    logic [63:0]       pal_wrdata;
    logic [7:0]        pal_byteena;
    logic [6:0]        spr_wraddr;
    logic              spr_wren;
    logic [63:0]       spr_wrdata;
    logic [7:0]        spr_byteena;
    logic              drop_err;
    logic [7:0]        drop_cnt;

    always #5 clk = ~clk;

    vram_wr_arbiter #(.DROP_CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_byteena  (req_byteena),
        .wr_stall     (wr_stall),
        .tile_wraddr  (tile_wraddr),
        .tile_wren    (tile_wren),
        .tile_wrdata  (tile_wrdata),
        .tile_byteena (tile_byteena),
        .pat_wraddr   (pat_wraddr),
        .pat_wren     (pat_wren),
        .pat_wrdata   (pat_wrdata),
        .pat_byteena  (pat_byteena),
        .pal_wraddr   (pal_wraddr),
        .pal_wren     (pal_wren),
        .pal_wrdata   (pal_wrdata),
        .pal_byteena  (pal_byteena),
        .spr_wraddr   (spr_wraddr),
        .spr_wren     (spr_wren),
        .spr_wrdata   (spr_wrdata),
        .spr_byteena  (spr_byteena),
        .drop_err     (drop_err),
        .drop_cnt     (drop_cnt)
    );

    // Region codes: 0 tile, 1 pattern, 2 palette, 3 sprite, 4 reserved.
    typedef struct {
        int          region;
        logic [11:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        int          nw;
        int          r;
        logic [11:0] a;
        logic [63:0] d;
        logic [7:0]  b;
        exp_t        e;
        nw = int'(tile_wren === 1'b1) + int'(pat_wren === 1'b1) +
             int'(pal_wren === 1'b1) + int'(spr_wren === 1'b1);
        r = 4;
        a = '0;
        d = '0;
        b = '0;
        if (tile_wren === 1'b1) begin
            r = 0; a = {1'b0, tile_wraddr}; d = tile_wrdata; b = tile_byteena;
        end else if (pat_wren === 1'b1) begin
            r = 1; a = pat_wraddr; d = pat_wrdata; b = pat_byteena;
        end else if (pal_wren === 1'b1) begin
            r = 2; a = {3'b0, pal_wraddr}; d = pal_wrdata; b = pal_byteena;
        end else if (spr_wren === 1'b1) begin
            r = 3; a = {5'b0, spr_wraddr}; d = spr_wrdata; b = spr_byteena;
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (nw != 1 || r != e.region || a !== e.addr || d !== e.data || b !== e.be) begin
                errors++;
                $display("FAIL wr_pulse: got n=%0d region=%0d addr=%0h data=%0h be=%0h, expected region=%0d addr=%0h data=%0h be=%0h (cycle %0d)",
                         nw, r, a, d, b, e.region, e.addr, e.data, e.be, cyc);
            end
        end else if (nw != 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_wren: got %0d pulses (region %0d addr %0h) expected none (cycle %0d)",
                     nw, r, a, cyc);
        end
    end

    task automatic set_req(input int i, input logic [12:0] a, input logic [63:0] d,
                           input logic [7:0] b);
        req_addr[i]    = a;
        req_data[i]    = d;
        req_byteena[i] = b;
    endtask

    task automatic push_exp(input int region, input logic [11:0] a, input logic [63:0] d,
                            input logic [7:0] b);
        sb.push_back('{region: region, addr: a, data: d, be: b, due: cyc + 1});
    endtask

    // Starts and ends just after a rising edge; consecutive calls are back-to-back.
    task automatic do_write(input int i, input logic [12:0] a, input logic [63:0] d,
                            input logic [7:0] b, input int region, input logic [11:0] loc);
        bit got;
        got = 1'b0;
        set_req(i, a, d, b);
        req_valid = 3'b001 << i;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) begin
                got = 1'b1;
                if (region != 4) push_exp(region, loc, d, b);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("grant_wait", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no end of test, required finish by 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    logic [12:0] rr_addr[3] = '{13'h0010, 13'h0900, 13'h1810};
    logic [63:0] rr_data[3] = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
                                64'hC2C2_0000_0000_0003};
    logic [7:0]  rr_be[3]   = '{8'hFF, 8'h0F, 8'hF0};
    int          rr_reg[3]  = '{0, 1, 2};
    logic [11:0] rr_loc[3]  = '{12'h010, 12'h100, 12'h010};

    initial begin
        logic [2:0] exp_rdy;
        wr_stall  = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) set_req(i, rr_addr[i], rr_data[i], rr_be[i]);

        // Reset with every requester asking.
        repeat (2) begin
            @(negedge clk);
            check("reset_ready", 64'(req_ready), 64'd0);
            check("reset_wren", 64'({tile_wren, pat_wren, pal_wren, spr_wren}), 64'd0);
        end
        check("reset_drop_err", 64'(drop_err), 64'd0);
        check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin from reset: 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_rdy = 3'b001 << (k % 3);
            check("rr_grant", 64'(req_ready), 64'(exp_rdy));
            push_exp(rr_reg[k % 3], rr_loc[k % 3], rr_data[k % 3], rr_be[k % 3]);
            @(posedge clk);
            #1;
        end
        req_valid = '0;

        // Region boundaries, plus a zero-byteena write that still pulses.
        do_write(1, 13'h07FF, 64'h1111_2222_3333_4444, 8'h81, 0, 12'h7FF);
        do_write(1, 13'h0800, 64'h5555_6666_7777_8888, 8'h42, 1, 12'h000);
        do_write(1, 13'h17FF, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 12'hFFF);
        do_write(1, 13'h1800, 64'hDEAD_BEEF_0000_0001, 8'h3C, 2, 12'h000);
        do_write(1, 13'h19FF, 64'h9999_AAAA_BBBB_CCCC, 8'h24, 2, 12'h1FF);
        do_write(1, 13'h1A7F, 64'hDDDD_EEEE_FFFF_0000, 8'h18, 3, 12'h07F);
        do_write(2, 13'h0005, 64'hCAFE_F00D_1234_5678, 8'h00, 0, 12'h005);

        // Reserved addresses are accepted but only counted.
        do_write(0, 13'h1A80, 64'h1, 8'hFF, 4, 12'h000);
        do_write(0, 13'h1FFF, 64'h2, 8'hFF, 4, 12'h000);
        check("drop_err", 64'(drop_err), 64'd1);
        check("drop_cnt_2", 64'(drop_cnt), 64'd2);
        for (int k = 0; k < 300; k++) do_write(0, 13'h1C00, 64'(k), 8'hFF, 4, 12'h000);
        check("drop_cnt_sat", 64'(drop_cnt), 64'd255);
        check("drop_err_hold", 64'(drop_err), 64'd1);

        // Stall: last grant was requester 0, so 2 goes first; its write drains
        // during the stall, then 0 and 2 resume.
        set_req(0, 13'h0020, 64'h7070_7070_0000_0020, 8'hE7);
        set_req(2, 13'h1A10, 64'h2222_0000_0000_1A10, 8'h5A);
        req_valid = 3'b101;
        @(negedge clk);
        check("pre_stall_grant", 64'(req_ready), 64'b100);
        push_exp(3, 12'h010, 64'h2222_0000_0000_1A10, 8'h5A);
        @(posedge clk);
        #1;
        wr_stall = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stall_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        wr_stall = 1'b0;
        @(negedge clk);
        check("post_stall_grant0", 64'(req_ready), 64'b001);
        push_exp(0, 12'h020, 64'h7070_7070_0000_0020, 8'hE7);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_stall_grant2", 64'(req_ready), 64'b100);
        push_exp(3, 12'h010, 64'h2222_0000_0000_1A10, 8'h5A);
        @(posedge clk);
        #1;
        req_valid = '0;

        // Reset right after a handshake drops the pending tile write.
        set_req(1, 13'h0100, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
        req_valid = 3'b010;
        @(negedge clk);
        check("mid_reset_grant", 64'(req_ready), 64'b010);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("mid_reset_tile_wren", 64'(tile_wren), 64'd0);
        check("mid_reset_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 3'b111;
        @(negedge clk);
        check("ptr_after_reset", 64'(req_ready), 64'b001);
        check("drop_err_cleared", 64'(drop_err), 64'd0);
        check("drop_cnt_cleared", 64'(drop_cnt), 64'd0);
        push_exp(0, 12'h020, 64'h7070_7070_0000_0020, 8'hE7);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        finish_run();
    end

endmodule
